// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: measures incoming HS/VS timing, tracks sync-relative pixel/line counters
// and declares lock after LOCK_FRAMES consecutive frames that match the expected mode.
// Ports: clk/rst_n (async active-low); hs_in/vs_in raw async syncs;
//   h_count/v_count sync-relative counters; line_start/frame_start leading-edge pulses;
//   h_total_meas/v_total_meas last measured line/frame size; locked status; err loss-of-lock pulse.
module vga_sync_monitor #(
  parameter int CW          = 10,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int HS_POL      = 0,
  parameter int VS_POL      = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hs_in,
  input  logic          vs_in,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] h_total_meas,
  output logic [CW-1:0] v_total_meas,
  output logic          locked,
  output logic          err
);

  localparam logic [CW-1:0] MAX       = {CW{1'b1}};
  localparam logic [CW-1:0] ONE       = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] H_TOTAL_C = CW'(H_TOTAL);
  localparam logic [CW-1:0] H_SYNC_C  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_TOTAL_C = CW'(V_TOTAL);
  localparam logic [CW-1:0] V_SYNC_C  = CW'(V_SYNC);
  localparam logic [3:0]    LOCK_C    = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t state, state_next;
  logic [2:0] good, good_next;
  logic       err_next;

  logic hs_meta, hs_sync, vs_meta, vs_sync;
  logic hs_act, vs_act, hs_act_q, vs_act_q;
  logic hs_edge, vs_edge, hs_fall, vs_fall;

  logic          h_run, v_run;
  logic [CW-1:0] h_inc, v_meas_next;
  logic [CW-1:0] hw_cnt, hs_width, vw_cnt, vs_width;
  logic          first_line, bad_seen;
  logic          line_bad, frame_ok, h_sat, enter_track;
  logic [3:0]    good_inc;

  // Two-flop synchronisers and edge history. The *_act_q flops come out of reset as
  // "already active" so a sync that happens to sit at its active level on reset
  // release is not mistaken for a leading edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_meta  <= 1'b0;
      hs_sync  <= 1'b0;
      vs_meta  <= 1'b0;
      vs_sync  <= 1'b0;
      hs_act_q <= 1'b1;
      vs_act_q <= 1'b1;
    end else begin
      hs_meta  <= hs_in;
      hs_sync  <= hs_meta;
      vs_meta  <= vs_in;
      vs_sync  <= vs_meta;
      hs_act_q <= hs_act;
      vs_act_q <= vs_act;
    end
  end

  assign hs_act  = (hs_sync == 1'(HS_POL));
  assign vs_act  = (vs_sync == 1'(VS_POL));
  assign hs_edge = hs_act & ~hs_act_q;
  assign vs_edge = vs_act & ~vs_act_q;
  assign hs_fall = ~hs_act & hs_act_q;
  assign vs_fall = ~vs_act & vs_act_q;

  // Saturating next values; h_inc doubles as the line length measured at an HS edge.
  assign h_inc       = (h_count == MAX) ? MAX : h_count + ONE;
  assign v_meas_next = (hs_edge && v_count != MAX) ? v_count + ONE : v_count;
  assign h_sat       = (h_count == MAX);

  // The first line after entering TRACK may be partial or carry a stale pulse width,
  // so it is not judged.
  assign line_bad = hs_edge && !first_line &&
                    ((h_inc != H_TOTAL_C) || (hs_width != H_SYNC_C));
  assign frame_ok = !(bad_seen || line_bad) &&
                    (v_meas_next == V_TOTAL_C) && (vs_width == V_SYNC_C);
  assign good_inc = {1'b0, good} + 4'd1;

  always_comb begin
    state_next = state;
    good_next  = good;
    err_next   = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_edge) begin
          state_next = TRACK;
          good_next  = 3'd0;
        end
      end
      TRACK: begin
        if (h_sat) begin
          state_next = SEARCH;
        end else if (vs_edge) begin
          if (frame_ok) begin
            good_next = good_inc[2:0];
            if (good_inc >= LOCK_C) state_next = LOCKED;
          end else begin
            good_next = 3'd0;
          end
        end
      end
      LOCKED: begin
        if (line_bad || h_sat || (vs_edge && !frame_ok)) begin
          state_next = SEARCH;
          err_next   = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  assign enter_track = (state != TRACK) && (state_next == TRACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SEARCH;
      good   <= 3'd0;
      err    <= 1'b0;
      locked <= 1'b0;
    end else begin
      state  <= state_next;
      good   <= good_next;
      err    <= err_next;
      // Follows the state register, so it lags err by one cycle on loss of lock.
      locked <= (state == LOCKED);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      h_run        <= 1'b0;
      v_run        <= 1'b0;
      h_count      <= '0;
      v_count      <= '0;
      h_total_meas <= '0;
      v_total_meas <= '0;
      hw_cnt       <= '0;
      hs_width     <= '0;
      vw_cnt       <= '0;
      vs_width     <= '0;
      bad_seen     <= 1'b0;
      first_line   <= 1'b0;
    end else begin
      line_start  <= hs_edge;
      frame_start <= vs_edge;
      // Counters stay at zero until the corresponding sync has been seen once.
      if (hs_edge) h_run <= 1'b1;
      if (vs_edge) v_run <= 1'b1;

      if (hs_edge) begin
        h_total_meas <= h_inc;
        h_count      <= '0;
      end else if (h_run) begin
        h_count <= h_inc;
      end

      // The edge cycle is itself an active cycle, hence restart at one.
      if (hs_edge)                        hw_cnt <= ONE;
      else if (hs_act && hw_cnt != MAX)   hw_cnt <= hw_cnt + ONE;
      if (hs_fall)                        hs_width <= hw_cnt;

      // VS wins a coincident HS edge; that HS edge lands in the measured height.
      if (vs_edge) begin
        v_total_meas <= v_meas_next;
        v_count      <= '0;
      end else if (hs_edge && v_run && v_count != MAX) begin
        v_count <= v_count + ONE;
      end

      if (vs_edge)                                 vw_cnt <= hs_edge ? ONE : '0;
      else if (vs_act && hs_edge && vw_cnt != MAX) vw_cnt <= vw_cnt + ONE;
      if (vs_fall)                                 vs_width <= vw_cnt;

      if (vs_edge)       bad_seen <= 1'b0;
      else if (line_bad) bad_seen <= 1'b1;

      if (enter_track)  first_line <= 1'b1;
      else if (hs_edge) first_line <= 1'b0;
    end
  end

endmodule
